// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the five-stage core: stall/flush/forward generation,
// a fixed-latency MUL/DIV occupancy FSM and wrap-around performance counters.
module hazard_ctrl_mc #(
  parameter int unsigned AW     = 5,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             CpuRst,
  input  logic             ICacheMiss,
  input  logic             DCacheMiss,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  input  logic [AW-1:0]    Rs1E,
  input  logic [AW-1:0]    Rs2E,
  input  logic [1:0]       RegReadD,
  input  logic [AW-1:0]    RdE,
  input  logic [AW-1:0]    RdM,
  input  logic [AW-1:0]    RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MulDivStartE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       Forward1E,
  output logic [1:0]       Forward2E,
  output logic             MulDivBusy,
  output logic             MulDivDone,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  localparam int unsigned CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic hit_e, hit_m, hit_w;
  logic data_hazard, md_stall, redirect;

  // A stage is a RAW producer when it writes a non-zero register that D reads.
  assign hit_e = RegWriteE && (RdE != '0) &&
                 ((RegReadD[1] && (Rs1D == RdE)) || (RegReadD[0] && (Rs2D == RdE)));
  assign hit_m = RegWriteM && (RdM != '0) &&
                 ((RegReadD[1] && (Rs1D == RdM)) || (RegReadD[0] && (Rs2D == RdM)));
  assign hit_w = RegWriteW && (RdW != '0) &&
                 ((RegReadD[1] && (Rs1D == RdW)) || (RegReadD[0] && (Rs2D == RdW)));

  assign data_hazard = FWD_EN ? (MemToRegE && hit_e) : (hit_e || hit_m || hit_w);
  assign md_stall    = ((state_q == StIdle) && MulDivStartE) || (state_q == StBusy);
  assign MulDivBusy  = (state_q == StBusy);
  assign MulDivDone  = (state_q == StDone);

  always_ff @(posedge clk or posedge CpuRst) begin
    if (CpuRst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // A data-cache miss freezes the whole unit, including the latency count.
    if (!DCacheMiss) begin
      unique case (state_q)
        StIdle: begin
          if (MulDivStartE) begin
            state_d = StBusy;
            cnt_d   = CW'(MD_LAT - 1);
          end
        end
        StBusy: begin
          if (cnt_q == CW'(1)) state_d = StDone;
          else                 cnt_d   = cnt_q - 1'b1;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    StallW   = 1'b0;
    FlushF   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FlushW   = 1'b0;
    redirect = 1'b0;
    if (CpuRst) begin
      FlushF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else if (DCacheMiss) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (md_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (BranchE || JalrE) begin
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      redirect = 1'b1;
    end else if (data_hazard) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (JalD) begin
      FlushD   = 1'b1;
      redirect = 1'b1;
    end else if (ICacheMiss) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  always_comb begin
    Forward1E = 2'b00;
    Forward2E = 2'b00;
    if (FWD_EN && !CpuRst) begin
      if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      Forward1E = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) Forward1E = 2'b01;
      if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      Forward2E = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) Forward2E = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge CpuRst) begin
    if (CpuRst) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      if (StallF)   StallCycles <= StallCycles + 1'b1;
      if (redirect) FlushEvents <= FlushEvents + 1'b1;
    end
  end

endmodule
